// File: rtl/combo_lock_pkg.sv
// ---------------------------------------------------------------------------
// combo_lock_pkg
// Shared types and constants for the combination-lock sequencer.
//   - NUM_DIGITS / MAX_ATTEMPTS / LOCKOUT_CYCLES : sequencing parameters
//   - IDX_W / ATT_W / CODE_W                     : derived port and register widths
//   - RESET_CODE                                 : power-on code, BCD, MSD first
//   - BCD_MAX                                    : largest legal digit value
//   - state_t                                    : sequencer states (ST_PROG only
//                                                  when CODE_CHANGE_EN is defined)
//   - disp_t                                     : display-select code for the HEX decoder
//   - codeDigit()                                : picks digit N (MSD = 0) out of a code
// ---------------------------------------------------------------------------
package combo_lock_pkg;

   localparam int NUM_DIGITS     = 6;
   localparam int MAX_ATTEMPTS   = 3;
   localparam int LOCKOUT_CYCLES = 16;

   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
   localparam int CODE_W = 4 * NUM_DIGITS;

   localparam logic [CODE_W-1:0] RESET_CODE = 24'h017028;
   localparam logic [3:0]        BCD_MAX    = 4'd9;

   typedef enum logic [2:0] {
      ST_ENTRY   = 3'd0,
      ST_OPEN    = 3'd1,
      ST_CLOSED  = 3'd2,
      ST_LOCKOUT = 3'd3
`ifdef CODE_CHANGE_EN
      , ST_PROG  = 3'd4
`endif
   } state_t;

   typedef enum logic [2:0] {
      DISP_DIGIT   = 3'd0,
      DISP_OPEN    = 3'd1,
      DISP_CLOSED  = 3'd2,
      DISP_ERROR   = 3'd3,
      DISP_LOCKOUT = 3'd4,
      DISP_PROG    = 3'd5
   } disp_t;

   // Digit 0 is the most significant nibble, so the first digit typed
   // is compared against the leftmost BCD digit of the code.
   function automatic logic [3:0] codeDigit(input logic [CODE_W-1:0] code,
                                            input logic [IDX_W-1:0]  idx);
      return code[(NUM_DIGITS - 1 - int'(idx)) * 4 +: 4];
   endfunction

endpackage

// File: rtl/combo_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// combo_lock_sequencer_if
// Bundles the keypad-side strobes and the status outputs of the sequencer.
//   master modport (keypad / testbench side):
//     out digit_valid, digit[3:0], relock, change_code
//     in  unlocked, locked_out, digit_idx, attempts_left, disp_sel
//   slave modport (combo_lock_sequencer side): the same signals, reversed.
// ---------------------------------------------------------------------------
interface combo_lock_sequencer_if;
   import combo_lock_pkg::*;

   logic             digit_valid;
   logic [3:0]       digit;
   logic             relock;
   logic             change_code;
   logic             unlocked;
   logic             locked_out;
   logic [IDX_W-1:0] digit_idx;
   logic [ATT_W-1:0] attempts_left;
   disp_t            disp_sel;

   modport master (
      output digit_valid, digit, relock, change_code,
      input  unlocked, locked_out, digit_idx, attempts_left, disp_sel
   );

   modport slave (
      input  digit_valid, digit, relock, change_code,
      output unlocked, locked_out, digit_idx, attempts_left, disp_sel
   );

endinterface

// File: rtl/combo_lock_sequencer_lockout_timer.sv
// ---------------------------------------------------------------------------
// lockout_timer
// Down-counter that measures the lockout period.
//   clk       in  system clock, rising edge
//   reset     in  synchronous, active-high
//   i_load    in  start a new period (asserted on the edge that enters lockout)
//   i_count   in  decrement while the sequencer sits in lockout
//   o_expired out high once the period is used up
// Loading CYCLES-1 means o_expired rises in the CYCLES-th cycle of
// lockout, so the sequencer leaves on the following edge after exactly
// CYCLES cycles.
// ---------------------------------------------------------------------------
module lockout_timer
   import combo_lock_pkg::*;
#(
   parameter int CYCLES = LOCKOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_count,
   output logic o_expired
);

   localparam int              CNT_W    = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   // Load has priority so a fresh lockout always restarts the full
   // period; the counter parks at zero instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= LOAD_VAL;
      end else if (i_count && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/combo_lock_sequencer.sv
// ---------------------------------------------------------------------------
// combo_lock_sequencer
// Sequencing controller for the 6-digit combination lock. Takes one BCD
// digit per strobe, compares the finished entry with the stored code,
// counts failed attempts and enforces a timed lockout.
//   clk    in    system clock, rising edge
//   reset  in    synchronous, active-high
//   bus    slave combo_lock_sequencer_if:
//            digit_valid, digit, relock, change_code  (inputs)
//            unlocked, locked_out, digit_idx,
//            attempts_left, disp_sel                   (registered outputs)
// Optional feature macro: CODE_CHANGE_EN
//   defined   : change_code in OPEN enters PROG and a new code can be typed.
//   undefined : the code is the constant RESET_CODE; change_code is ignored.
// ---------------------------------------------------------------------------
module combo_lock_sequencer
   import combo_lock_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   combo_lock_sequencer_if.slave  bus
);

   state_t           r_state;
   logic [IDX_W-1:0] r_digitIdx;
   logic [ATT_W-1:0] r_attempts;
   logic             r_match;
   disp_t            r_disp;

   state_t           w_nextState;
   logic [IDX_W-1:0] w_nextIdx;
   logic [ATT_W-1:0] w_nextAttempts;
   logic             w_nextMatch;
   disp_t            w_nextDisp;
   logic             w_loadTimer;
   logic             w_inLockout;
   logic             w_timerExpired;

   logic [CODE_W-1:0] w_code;
   logic              w_digitOk;
   logic              w_digitMatch;
   logic              w_entryMatch;
   logic              w_lastDigit;

`ifdef CODE_CHANGE_EN
   logic [CODE_W-1:0] r_code;
   logic [CODE_W-1:0] r_shadow;
   logic [CODE_W-1:0] w_nextCode;
   logic [CODE_W-1:0] w_nextShadow;

   assign w_code = r_code;
`else
   logic w_unusedChangeCode;

   assign w_code             = RESET_CODE;
   assign w_unusedChangeCode = bus.change_code;
`endif

   // A digit only counts as a match when it is legal BCD and equals the
   // code digit at the current position. In CLOSED the index is already
   // back at zero, so the same compare serves the first digit of a retry.
   assign w_digitOk    = (bus.digit <= BCD_MAX);
   assign w_digitMatch = w_digitOk && (bus.digit == codeDigit(w_code, r_digitIdx));
   assign w_entryMatch = r_match && w_digitMatch;
   assign w_lastDigit  = (r_digitIdx == IDX_W'(NUM_DIGITS - 1));
   assign w_inLockout  = (r_state == ST_LOCKOUT);

   lockout_timer #(
      .CYCLES    (LOCKOUT_CYCLES)
   ) u_lockoutTimer (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_loadTimer),
      .i_count   (w_inLockout),
      .o_expired (w_timerExpired)
   );

   // State and status registers. The display code is registered along
   // with the state so every output moves on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_ENTRY;
         r_digitIdx <= '0;
         r_attempts <= ATT_W'(MAX_ATTEMPTS);
         r_match    <= 1'b1;
         r_disp     <= DISP_DIGIT;
      end else begin
         r_state    <= w_nextState;
         r_digitIdx <= w_nextIdx;
         r_attempts <= w_nextAttempts;
         r_match    <= w_nextMatch;
         r_disp     <= w_nextDisp;
      end
   end

`ifdef CODE_CHANGE_EN
   // The stored code only changes on a completed PROG entry; reset
   // always brings back the power-on code.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_code   <= RESET_CODE;
         r_shadow <= '0;
      end else begin
         r_code   <= w_nextCode;
         r_shadow <= w_nextShadow;
      end
   end
`endif

   // Next-state logic. A wrong digit never ends an entry early; it only
   // clears the match flag so the failing position stays hidden. The index
   // wraps to zero on the same edge that makes the open/closed decision.
   // relock is tested before anything else in the states where it matters.
   always_comb begin
      w_nextState    = r_state;
      w_nextIdx      = r_digitIdx;
      w_nextAttempts = r_attempts;
      w_nextMatch    = r_match;
      w_nextDisp     = r_disp;
      w_loadTimer    = 1'b0;
`ifdef CODE_CHANGE_EN
      w_nextCode     = r_code;
      w_nextShadow   = r_shadow;
`endif

      case (r_state)
         ST_ENTRY: begin
            if (bus.digit_valid) begin
               if (w_lastDigit) begin
                  w_nextIdx   = '0;
                  w_nextMatch = 1'b1;
                  if (w_entryMatch) begin
                     w_nextState    = ST_OPEN;
                     w_nextAttempts = ATT_W'(MAX_ATTEMPTS);
                     w_nextDisp     = DISP_OPEN;
                  end else if (r_attempts <= ATT_W'(1)) begin
                     w_nextState    = ST_LOCKOUT;
                     w_nextAttempts = '0;
                     w_nextDisp     = DISP_LOCKOUT;
                     w_loadTimer    = 1'b1;
                  end else begin
                     w_nextState    = ST_CLOSED;
                     w_nextAttempts = r_attempts - ATT_W'(1);
                     w_nextDisp     = DISP_CLOSED;
                  end
               end else begin
                  w_nextIdx   = r_digitIdx + IDX_W'(1);
                  w_nextMatch = w_entryMatch;
                  w_nextDisp  = w_digitOk ? DISP_DIGIT : DISP_ERROR;
               end
            end
         end

         ST_CLOSED: begin
            if (bus.digit_valid) begin
               w_nextState = ST_ENTRY;
               w_nextIdx   = IDX_W'(1);
               w_nextMatch = w_digitMatch;
               w_nextDisp  = w_digitOk ? DISP_DIGIT : DISP_ERROR;
            end
         end

         ST_OPEN: begin
            if (bus.relock) begin
               w_nextState = ST_ENTRY;
               w_nextIdx   = '0;
               w_nextMatch = 1'b1;
               w_nextDisp  = DISP_DIGIT;
            end
`ifdef CODE_CHANGE_EN
            else if (bus.change_code) begin
               w_nextState = ST_PROG;
               w_nextIdx   = '0;
               w_nextDisp  = DISP_PROG;
            end
`endif
         end

         ST_LOCKOUT: begin
            if (w_timerExpired) begin
               w_nextState    = ST_ENTRY;
               w_nextIdx      = '0;
               w_nextAttempts = ATT_W'(MAX_ATTEMPTS);
               w_nextMatch    = 1'b1;
               w_nextDisp     = DISP_DIGIT;
            end
         end

`ifdef CODE_CHANGE_EN
         ST_PROG: begin
            if (bus.relock || (bus.digit_valid && !w_digitOk)) begin
               w_nextState = ST_OPEN;
               w_nextIdx   = '0;
               w_nextDisp  = DISP_OPEN;
            end else if (bus.digit_valid) begin
               w_nextShadow = {r_shadow[CODE_W-5:0], bus.digit};
               if (w_lastDigit) begin
                  w_nextCode  = {r_shadow[CODE_W-5:0], bus.digit};
                  w_nextState = ST_OPEN;
                  w_nextIdx   = '0;
                  w_nextDisp  = DISP_OPEN;
               end else begin
                  w_nextIdx = r_digitIdx + IDX_W'(1);
               end
            end
         end
`endif

         default: begin
            w_nextState = ST_ENTRY;
            w_nextIdx   = '0;
            w_nextMatch = 1'b1;
            w_nextDisp  = DISP_DIGIT;
         end
      endcase
   end

   // unlocked and locked_out are plain decodes of the state register.
   assign bus.unlocked      = (r_state == ST_OPEN);
   assign bus.locked_out    = (r_state == ST_LOCKOUT);
   assign bus.digit_idx     = r_digitIdx;
   assign bus.attempts_left = r_attempts;
   assign bus.disp_sel      = r_disp;

endmodule
